// File: rtl/frame_mem_responder.sv
// frame_mem_responder: single-port RAM responder for the frame-buffer write and
// read initiators. Active-low requests are arbitrated onto one RAM port and each
// completes with a one-cycle wr_rdy or rd_data_valid pulse. All outputs registered.
module frame_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_rdy,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    // last_grant encoding: 1 = read side was served last
    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    // A one-bit counter is kept even for RD_LATENCY=1 so the width is never zero
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    logic [1:0]            state;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [CNT_W-1:0]      cnt;
    logic                  wr_req;
    logic                  rd_req;
    logic                  pick_wr;

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    // Arbitration: a lone request wins; on a tie the side not served last wins
    always_comb begin
        wr_req  = ~wr_en;
        rd_req  = ~rd_en;
        pick_wr = wr_req && (!rd_req || (last_grant == GRANT_RD));
    end

    // Main FSM: grant, RAM access, completion pulse, one-cycle ACK holdoff
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            last_grant    <= GRANT_RD;
            addr          <= '0;
            data          <= '0;
            cnt           <= '0;
            wr_rdy        <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // last_grant follows every grant, so ties alternate fairly
                    if (pick_wr) begin
                        addr       <= wr_addr;
                        data       <= wr_data;
                        last_grant <= GRANT_WR;
                        state      <= S_WR;
                        busy       <= 1'b1;
                    end else if (rd_req) begin
                        addr       <= rd_addr;
                        cnt        <= CNT_LOAD;
                        last_grant <= GRANT_RD;
                        state      <= S_RD;
                        busy       <= 1'b1;
                    end
                end
                S_WR: begin
                    wr_rdy <= 1'b1;
                    state  <= S_ACK;
                end
                S_RD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rd_data       <= mem[addr];
                        rd_data_valid <= 1'b1;
                        state         <= S_ACK;
                    end
                end
                S_ACK: begin
                    // Requests ignored here so the initiator can move its address on
                    wr_rdy        <= 1'b0;
                    rd_data_valid <= 1'b0;
                    state         <= S_IDLE;
                    busy          <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM write port; contents survive reset, but a reset edge aborts the write
    always_ff @(posedge clk) begin
        if (!reset && state == S_WR) begin
            mem[addr] <= data;
        end
    end

endmodule

// File: tb/tb_frame_mem_responder.sv
// Scoreboard bench for frame_mem_responder: stimulus pushes expected completions,
// a negedge monitor pops and checks every wr_rdy / rd_data_valid pulse.
module tb_frame_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  wr_addr;
    logic [2:0]  rd_addr;
    logic [31:0] wr_data;
    logic        wr_rdy;
    logic        rd_data_valid;
    logic [31:0] rd_data;
    logic        busy;

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   fails   = 0;

    frame_mem_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(3),
        .RD_LATENCY(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .wr_data      (wr_data),
        .wr_rdy       (wr_rdy),
        .rd_data_valid(rd_data_valid),
        .rd_data      (rd_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (wr_rdy && rd_data_valid) chk("both_pulses", 32'd1, 32'd0);
        if (wr_rdy || rd_data_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {31'd0, rd_data_valid}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                if (wr_rdy) begin
                    chk("pulse_kind_wr", {31'd0, e.is_wr}, 32'd1);
                end else begin
                    chk("pulse_kind_rd", {31'd0, e.is_wr}, 32'd0);
                    chk("rd_data", rd_data, e.data);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, n >= 50}, 32'd0);
    endtask

    // Issue one request at an idle negedge; hold it low for 'hold' extra edges
    // after the grant, then scramble the inputs to prove they were latched.
    task automatic issue(input bit wr, input logic [2:0] a, input logic [31:0] d,
                         input int hold, input bit expect_it);
        exp_t e;
        @(negedge clk);
        wait_idle();
        if (wr) begin
            wr_en = 1'b0; wr_addr = a; wr_data = d;
        end else begin
            rd_en = 1'b0; rd_addr = a;
        end
        if (expect_it) begin
            e.is_wr = wr;
            e.data  = d;
            q.push_back(e);
        end
        @(posedge clk);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b1;
        wr_addr = ~a; rd_addr = ~a; wr_data = ~d;
        wait_idle();
    endtask

    task automatic wait_rd_pulse();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_data_valid && n < 60);
        chk("rd_pulse_timeout", {31'd0, n >= 60}, 32'd0);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        wr_addr = '0; rd_addr = '0; wr_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_rdy", {31'd0, wr_rdy}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_data_valid}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Write addr 3 with cycle-exact pulse/busy timing
        wr_en = 1'b0; wr_addr = 3'd3; wr_data = 32'hDEADBEEF;
        e.is_wr = 1'b1; e.data = '0; q.push_back(e);
        @(posedge clk);                 // E0: grant
        @(negedge clk); wr_en = 1'b1;
        chk("wr_e0_busy", {31'd0, busy}, 32'd1);
        chk("wr_e0_rdy", {31'd0, wr_rdy}, 32'd0);
        @(negedge clk);                 // after E1
        chk("wr_e1_rdy", {31'd0, wr_rdy}, 32'd1);
        chk("wr_e1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);                 // after E2
        chk("wr_e2_rdy", {31'd0, wr_rdy}, 32'd0);
        chk("wr_e2_busy", {31'd0, busy}, 32'd0);

        // Read addr 3, latency 2
        rd_en = 1'b0; rd_addr = 3'd3;
        e.is_wr = 1'b0; e.data = 32'hDEADBEEF; q.push_back(e);
        @(posedge clk);                 // E0
        @(negedge clk); rd_en = 1'b1;
        chk("rd_e0_valid", {31'd0, rd_data_valid}, 32'd0);
        chk("rd_e0_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("rd_e1_valid", {31'd0, rd_data_valid}, 32'd0);
        @(negedge clk);
        chk("rd_e2_valid", {31'd0, rd_data_valid}, 32'd1);
        @(negedge clk);
        chk("rd_e3_valid", {31'd0, rd_data_valid}, 32'd0);
        chk("rd_e3_busy", {31'd0, busy}, 32'd0);
        chk("rd_data_hold", rd_data, 32'hDEADBEEF);

        // Reset during the first RD cycle aborts the read with no pulse
        @(negedge clk);
        rd_en = 1'b0; rd_addr = 3'd3;
        @(posedge clk);                 // E0: grant
        @(negedge clk); rd_en = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("abort_valid", {31'd0, rd_data_valid}, 32'd0);
        chk("abort_rd_data", rd_data, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        issue(1'b0, 3'd3, 32'hDEADBEEF, 0, 1'b1);

        // Read request dropped one cycle after grant, address changed: still completes
        issue(1'b1, 3'd2, 32'hA5A5_1234, 0, 1'b1);
        issue(1'b0, 3'd2, 32'hA5A5_1234, 1, 1'b1);

        // Sweep all addresses
        for (int i = 0; i < 8; i++) issue(1'b1, 3'(i), 32'h1111 * i, 0, 1'b1);
        for (int i = 0; i < 8; i++) issue(1'b0, 3'(i), 32'h1111 * i, 0, 1'b1);

        // Both requests held low from reset: W,R,W,R alternation
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = 3'd5; wr_data = 32'h0BAD_F00D; rd_addr = 3'd5;
        e.is_wr = 1'b1; e.data = '0;            q.push_back(e);
        e.is_wr = 1'b0; e.data = 32'h0BAD_F00D; q.push_back(e);
        e.is_wr = 1'b1; e.data = '0;            q.push_back(e);
        e.is_wr = 1'b0; e.data = 32'h1234_5678; q.push_back(e);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_rd_pulse();
        wr_addr = 3'd6; wr_data = 32'h1234_5678; rd_addr = 3'd6;
        wait_rd_pulse();
        wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        wait_idle();

        repeat (6) @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
